// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset constants
// and the PC arithmetic helpers used by the fetch logic.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IF_BOOT  = 2'd0,
        IF_RUN   = 2'd1,
        IF_FLUSH = 2'd2
    } if_state_t;

    localparam logic [31:0] IF_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] IF_BOOT_PC  = 32'h0000_0000;
    localparam logic [31:0] IF_PC_INC   = 32'd4;

    function automatic logic [31:0] if_word_align(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// In-order fetch queue holding {instruction, pc} pairs; head is readable without latency
// so the register-fetch stage sees a word the cycle after it is pushed.
module if_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic                         push,
    input  logic [31:0]                  push_data,
    input  logic [31:0]                  push_pc,
    input  logic                         pop,
    input  logic                         clear,
    output logic [31:0]                  head_data,
    output logic [31:0]                  head_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push, do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign count     = count_reg;
    assign do_pop    = pop & ~empty & ~clear;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push   = push & (~full | do_pop) & ~clear;
    assign head_data = data_mem[rd_ptr_reg];
    assign head_pc   = pc_mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr_reg] <= push_data;
            pc_mem[wr_ptr_reg]   <= push_pc;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues imem requests, drops wrong-path
// responses after a redirect. Define IF_PERF_CNT_EN to add stall/fetch counters.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] BOOT_PC  = IF_BOOT_PC,
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] NOP_WORD = IF_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        pause,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o,
    output logic        ins_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] fetch_cnt_o
`endif
);
    localparam int CW = $clog2(QDEPTH+1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    if_state_t     state_reg;
    logic [31:0]   fetch_pc_reg, pc_hold_reg;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic [PW-1:0] pf_wr_ptr_reg, pf_rd_ptr_reg;
    logic [31:0]   pc_fifo_mem [QDEPTH];
    logic [CW:0]   inflight;
    logic          grant, resp, push, pop;
    logic [CW-1:0] q_count;
    logic          q_empty, q_full;
    logic [31:0]   q_head_data, q_head_pc;

    // Requests are throttled so every granted word is guaranteed a queue slot.
    assign inflight    = {1'b0, outstanding_reg} + {1'b0, q_count};
    assign imem_req_o  = (state_reg == IF_RUN) && (inflight < (CW+1)'(QDEPTH));
    assign imem_addr_o = fetch_pc_reg;
    assign grant       = imem_req_o & imem_gnt_i;
    assign resp        = imem_rvalid_i & (outstanding_reg != '0);
    assign push        = resp & (discard_reg == '0) & ~redirect_i;

    assign ins_valid_o = ~q_empty;
    assign ins_o       = q_empty ? NOP_WORD : q_head_data;
    assign pc_o        = q_empty ? pc_hold_reg : q_head_pc;
    assign pop         = ins_valid_o & ~pause;

    always_comb begin
        outstanding_next = outstanding_reg + CW'(grant) - CW'(resp);
        discard_next     = discard_reg;
        if (redirect_i)
            discard_next = outstanding_next;
        else if (resp && discard_reg != '0)
            discard_next = discard_reg - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_reg       <= IF_BOOT;
            fetch_pc_reg    <= BOOT_PC;
            pc_hold_reg     <= BOOT_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            pf_wr_ptr_reg   <= '0;
            pf_rd_ptr_reg   <= '0;
        end else begin
            if (redirect_i) begin
                state_reg <= (discard_next != '0) ? IF_FLUSH : IF_RUN;
            end else begin
                case (state_reg)
                    IF_BOOT:  state_reg <= IF_RUN;
                    IF_RUN:   state_reg <= IF_RUN;
                    IF_FLUSH: if (discard_reg == '0) state_reg <= IF_RUN;
                    default:  state_reg <= IF_RUN;
                endcase
            end
            if (redirect_i)
                fetch_pc_reg <= if_word_align(redirect_pc_i);
            else if (grant)
                fetch_pc_reg <= fetch_pc_reg + IF_PC_INC;
            pc_hold_reg     <= pc_o;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            if (grant) pf_wr_ptr_reg <= pf_wr_ptr_reg + PW'(1);
            if (resp)  pf_rd_ptr_reg <= pf_rd_ptr_reg + PW'(1);
        end
    end

    // PC of each outstanding request, consumed in order as responses come back.
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_pc_fifo
        always_ff @(posedge clk) begin
            if (grant && pf_wr_ptr_reg == PW'(gi))
                pc_fifo_mem[gi] <= fetch_pc_reg;
        end
    end

    if_fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (imem_rdata_i),
        .push_pc   (pc_fifo_mem[pf_rd_ptr_reg]),
        .pop       (pop),
        .clear     (redirect_i),
        .head_data (q_head_data),
        .head_pc   (q_head_pc),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_reg, fetch_cnt_reg;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
            fetch_cnt_reg <= '0;
        end else begin
            if (!ins_valid_o && !pause && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (pop && fetch_cnt_reg != '1)
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign fetch_cnt_o = fetch_cnt_reg;
`endif

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_i)
        imem_rvalid_i |-> (outstanding_reg != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_i)
        !(push && q_full && !pop));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: queue-based reference model checked every cycle,
// plus hand-computed expectations on issued addresses and delivered instructions.
module tb_if_fetch_stage;

    localparam int          QDEPTH = 2;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        pause = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] ins_o, pc_o;
    logic        ins_valid_o;

    always #5 clk = ~clk;

    if_fetch_stage #(.BOOT_PC(32'h0), .QDEPTH(QDEPTH), .NOP_WORD(NOP)) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .pause         (pause),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .ins_o         (ins_o),
        .pc_o          (pc_o),
        .ins_valid_o   (ins_valid_o)
    );

    typedef struct {logic [31:0] pc; bit drop;} req_t;
    typedef struct {logic [31:0] ins; logic [31:0] pc;} ent_t;

    int checks = 0;
    int passed = 0;

    // Reference model state
    req_t        m_infl[$];
    ent_t        m_outq[$];
    logic [31:0] m_fpc = 32'h0;
    logic [31:0] m_last_pc = 32'h0;
    bit          m_booted = 0;
    bit          m_flushing = 0;

    // Memory agent and logs
    logic [31:0] pend[$];
    logic [31:0] glog[$];
    ent_t        plog[$];
    bit          resp_hold = 0;
    bit          rst_drive = 0;
    int          kcyc = 0;
    int          first_valid = -1;
    bit          hunt = 0, hit = 0;
    logic [31:0] hunt_pc = '0;
    int          hit_gidx = 0, hit_pidx = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s (cycle %0d): got %h, required %h", name, kcyc, act, exp);
    endtask

    task automatic model_update(input bit p, input bit r, input logic [31:0] rpc,
                                input bit grant, input logic [31:0] cur_pc);
        bit   had_drops;
        req_t e;
        had_drops = 0;
        foreach (m_infl[i]) if (m_infl[i].drop) had_drops = 1;
        if (m_outq.size() > 0 && !p) void'(m_outq.pop_front());
        if (imem_rvalid_i && m_infl.size() > 0) begin
            e = m_infl.pop_front();
            if (!e.drop && !r) m_outq.push_back(ent_t'{ins: imem_rdata_i, pc: e.pc});
        end
        if (grant) begin
            m_infl.push_back(req_t'{pc: m_fpc, drop: 1'b0});
            m_fpc = m_fpc + 32'd4;
        end
        m_last_pc = cur_pc;
        if (r) begin
            m_outq.delete();
            foreach (m_infl[i]) m_infl[i].drop = 1'b1;
            m_fpc      = {rpc[31:2], 2'b00};
            m_booted   = 1;
            m_flushing = (m_infl.size() > 0);
        end else if (!m_booted) begin
            m_booted = 1;
        end else if (m_flushing && !had_drops) begin
            m_flushing = 0;
        end
    endtask

    task automatic cyc(input bit p_in, input bit r_in, input logic [31:0] rpc_in, input bit g_in);
        bit          p, r, g, e_req, e_valid;
        logic [31:0] rpc, e_ins, e_pc;
        @(negedge clk);
        p = p_in; r = r_in; rpc = rpc_in; g = g_in;
        if (hunt && ins_valid_o && pend.size() > 0 && !resp_hold) begin
            p = 0; r = 1; rpc = hunt_pc; g = 0;
            hunt = 0; hit = 1;
            hit_gidx = glog.size();
            hit_pidx = plog.size();
        end
        rst_i = rst_drive;
        pause = p; redirect_i = r; redirect_pc_i = rpc; imem_gnt_i = g;
        if (pend.size() > 0 && !resp_hold) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
        #1;
        e_req   = m_booted && !m_flushing && (m_infl.size() + m_outq.size() < QDEPTH);
        e_valid = (m_outq.size() > 0);
        e_ins   = e_valid ? m_outq[0].ins : NOP;
        e_pc    = e_valid ? m_outq[0].pc : m_last_pc;
        chk("imem_req", {31'b0, imem_req_o}, {31'b0, e_req});
        chk("imem_addr", imem_addr_o, m_fpc);
        chk("ins_valid", {31'b0, ins_valid_o}, {31'b0, e_valid});
        chk("ins", ins_o, e_ins);
        chk("pc", pc_o, e_pc);
        if (rst_drive) begin
            if (ins_valid_o && first_valid < 0) first_valid = kcyc;
            if (ins_valid_o && !p && !r) plog.push_back(ent_t'{ins: ins_o, pc: pc_o});
            if (imem_req_o && g) begin
                pend.push_back(imem_addr_o);
                glog.push_back(imem_addr_o);
            end
            model_update(p, r, rpc, e_req && g, e_pc);
            kcyc++;
        end
    endtask

    initial begin
        int pidx, gidx, nseq;

        // Reset held: outputs at reset values
        repeat (3) cyc(0, 0, 32'h0, 1);
        rst_drive = 1;

        // Zero-wait streaming from BOOT_PC
        repeat (10) cyc(0, 0, 32'h0, 1);
        chk("first_valid_cycle", first_valid, 3);
        chk("boot_grants_ge3", {31'b0, glog.size() >= 3}, 32'd1);
        chk("boot_pops_ge3", {31'b0, plog.size() >= 3}, 32'd1);
        chk("grant_addr0", glog[0], 32'h0);
        chk("grant_addr1", glog[1], 32'h4);
        chk("grant_addr2", glog[2], 32'h8);
        chk("pop0_pc", plog[0].pc, 32'h0);
        chk("pop0_ins", plog[0].ins, 32'hECA8_6420);
        chk("pop1_pc", plog[1].pc, 32'h4);
        chk("pop2_pc", plog[2].pc, 32'h8);

        // Pause for 5 cycles mid-stream, then resume
        repeat (5) cyc(1, 0, 32'h0, 1);
        repeat (8) cyc(0, 0, 32'h0, 1);
        nseq = plog.size();
        for (int i = 0; i < nseq; i++) begin
            chk("seq_pc", plog[i].pc, 32'(4 * i));
            chk("seq_ins", plog[i].ins, mem_word(32'(4 * i)));
        end

        // Two requests outstanding, then redirect to 0x100
        resp_hold = 1;
        repeat (4) cyc(0, 0, 32'h0, 1);
        chk("outstanding_before_redirect", pend.size(), 32'd2);
        pidx = plog.size();
        gidx = glog.size();
        cyc(0, 1, 32'h100, 0);
        resp_hold = 0;
        repeat (8) cyc(0, 0, 32'h0, 1);
        chk("redir_pops", {31'b0, plog.size() > pidx}, 32'd1);
        chk("redir_first_grant", glog[gidx], 32'h100);
        chk("redir_first_pc", plog[pidx].pc, 32'h100);
        chk("redir_first_ins", plog[pidx].ins, 32'hECA8_6520);

        // Grant withheld for 4 cycles
        repeat (4) cyc(0, 0, 32'h0, 0);
        repeat (4) cyc(0, 0, 32'h0, 1);

        // Fetch PC wrap at the top of the address space
        gidx = glog.size();
        cyc(0, 1, 32'hFFFF_FFF8, 0);
        repeat (14) cyc(0, 0, 32'h0, 1);
        chk("wrap_grants", {31'b0, glog.size() >= gidx + 3}, 32'd1);
        chk("wrap_addr0", glog[gidx], 32'hFFFF_FFF8);
        chk("wrap_addr1", glog[gidx + 1], 32'hFFFF_FFFC);
        chk("wrap_addr2", glog[gidx + 2], 32'h0000_0000);

        // Redirect to an unaligned target coincident with rvalid and a pop
        hunt = 1; hunt_pc = 32'h103; hit = 0;
        for (int i = 0; i < 20 && !hit; i++) cyc(1, 0, 32'h0, 1);
        chk("coincident_redirect_found", {31'b0, hit}, 32'd1);
        hunt = 0;
        repeat (10) cyc(0, 0, 32'h0, 1);
        chk("unaligned_grant", glog[hit_gidx], 32'h100);
        chk("unaligned_first_pc", plog[hit_pidx].pc, 32'h100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got no summary, required completion");
        $fatal(1);
    end

endmodule
